// File: rtl/llr_frame_feeder_if.sv
// Stream bundle around the LLR frame feeder: input LLR stream, decoder
// injection port, decoder status, and the result handshake.
//
// Handshake rules (both s_* and r_* channels): a beat transfers on a rising
// clk edge where valid & ready are both 1; the producer keeps data stable and
// valid asserted until that edge, and valid never depends on ready.
// The d_* channel has no ready: the decoder must take every d_val beat.
interface llr_frame_feeder_if #(
    parameter int N      = 12,
    parameter int W      = 6,
    parameter int IN_W   = 8,
    parameter int LANES  = 1,
    parameter int LOOP_W = 7
) ();
    logic signed [IN_W-1:0]    s_data;
    logic                      s_val;
    logic                      s_rdy;

    logic [LANES*W-1:0]        d_data;
    logic                      d_val;
    logic                      d_first;

    logic                      dec_o_val;
    logic [N-1:0]              dec_estimate;
    logic [LOOP_W-1:0]         dec_loop;

    logic [N-1:0]              r_estimate;
    logic                      r_timeout;
    logic                      r_sat;
    logic                      r_val;
    logic                      r_rdy;

    // Environment side: LLR source, decoder and result consumer.
    modport master (
        output s_data, s_val, dec_o_val, dec_estimate, dec_loop, r_rdy,
        input  s_rdy, d_data, d_val, d_first, r_estimate, r_timeout, r_sat, r_val
    );

    // Feeder side.
    modport slave (
        input  s_data, s_val, dec_o_val, dec_estimate, dec_loop, r_rdy,
        output s_rdy, d_data, d_val, d_first, r_estimate, r_timeout, r_sat, r_val
    );
endinterface

// File: rtl/llr_frame_feeder.sv
// LLR frame feeder: saturates incoming LLRs into a ping-pong frame buffer,
// streams each full frame to the LDPC decoder LANES LLRs per cycle, waits for
// convergence or iteration exhaustion and holds the hard-decision result
// until the consumer takes it. dbg_state mirrors the FSM for observation.
module llr_frame_feeder #(
    parameter int N        = 12,
    parameter int W        = 6,
    parameter int IN_W     = 8,
    parameter int LANES    = 1,
    parameter int LOOP_W   = 7,
    parameter int LOOP_MAX = 100
) (
    input  logic                clk,
    input  logic                xrst,
    llr_frame_feeder_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int BEATS = N / LANES;
    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Symmetric clamp limits expressed at input width.
    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((1 << (W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t         state, state_nx;

    logic [W-1:0]   mem [2][N];
    logic [1:0]     full;
    logic [1:0]     sat;
    logic           wbank;
    logic           rbank;
    logic [AW-1:0]  wcnt;
    logic [BW-1:0]  bcnt;
    logic           live;

    logic [W-1:0]   llr_sat;
    logic           llr_clamp;
    logic           accept;
    logic           last_beat;
    logic           capture;
    logic           release_bank;

    assign accept       = bus.s_val & bus.s_rdy;
    assign last_beat    = (bcnt == BW'(BEATS - 1));
    assign capture      = (state == WAIT) &&
                          (bus.dec_o_val || (bus.dec_loop == LOOP_W'(LOOP_MAX)));
    assign release_bank = (state == HOLD) && bus.r_rdy;
    assign dbg_state    = state;

    // Clamp the incoming LLR to the symmetric decoder range and flag clamps.
    always_comb begin
        llr_clamp = 1'b0;
        llr_sat   = bus.s_data[W-1:0];
        if ($signed(bus.s_data) > SAT_HI) begin
            llr_sat   = SAT_HI[W-1:0];
            llr_clamp = 1'b1;
        end else if ($signed(bus.s_data) < SAT_LO) begin
            llr_sat   = SAT_LO[W-1:0];
            llr_clamp = 1'b1;
        end
    end

    // Frame buffer storage; contents need no reset since full flags gate use.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank][wcnt] <= llr_sat;
        end
    end

    // Bank bookkeeping: load pointer, full/sat flags, bank release on result.
    // Loading only targets a non-full bank and release only a full one, so
    // both updates touch different banks when they coincide.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            live  <= 1'b0;
            full  <= 2'b00;
            sat   <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
        end else begin
            live <= 1'b1;
            if (release_bank) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
            if (accept) begin
                if (wcnt == '0) begin
                    sat[wbank] <= llr_clamp;
                end else begin
                    sat[wbank] <= sat[wbank] | llr_clamp;
                end
                if (wcnt == AW'(N - 1)) begin
                    wcnt        <= '0;
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end else begin
                    wcnt <= wcnt + AW'(1);
                end
            end
        end
    end

    // FSM state register and beat counter for the FEED phase.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= IDLE;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == FEED && !last_beat) begin
                bcnt <= bcnt + BW'(1);
            end else begin
                bcnt <= '0;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (full[rbank])  state_nx = FEED;
            FEED:    if (last_beat)    state_nx = WAIT;
            WAIT:    if (capture)      state_nx = HOLD;
            HOLD:    if (bus.r_rdy)    state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    // Handshake and decoder-side outputs derived from state and flags.
    always_comb begin
        bus.s_rdy   = live & ~full[wbank];
        bus.d_val   = (state == FEED);
        bus.d_first = (state == FEED) && (bcnt == '0);
        bus.r_val   = (state == HOLD);
        bus.d_data  = '0;
        if (state == FEED) begin
            for (int l = 0; l < LANES; l++) begin
                bus.d_data[l*W +: W] = mem[rbank][AW'(bcnt * LANES + l)];
            end
        end
    end

    // Result capture: convergence takes priority over iteration exhaustion.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            bus.r_estimate <= '0;
            bus.r_timeout  <= 1'b0;
            bus.r_sat      <= 1'b0;
        end else if (capture) begin
            bus.r_estimate <= bus.dec_estimate;
            bus.r_timeout  <= ~bus.dec_o_val;
            bus.r_sat      <= sat[rbank];
        end
    end
endmodule

// File: tb/tb_llr_frame_feeder.sv
// Directed bench for llr_frame_feeder: single-lane instance for the main
// flows (load, feed, convergence, saturation, timeout, ping-pong, reset) and
// a four-lane instance for lane packing.
module tb_llr_frame_feeder;
    localparam int N      = 12;
    localparam int W      = 6;
    localparam int IN_W   = 8;
    localparam int LOOP_W = 7;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic xrst = 1'b0;
    always #5 clk = ~clk;

    llr_frame_feeder_if #(.N(N), .W(W), .IN_W(IN_W), .LANES(1), .LOOP_W(LOOP_W)) bus ();
    llr_frame_feeder_if #(.N(N), .W(W), .IN_W(IN_W), .LANES(4), .LOOP_W(LOOP_W)) bus4 ();
    logic [1:0] dbg_state;
    logic [1:0] dbg_state4;

    llr_frame_feeder #(.N(N), .W(W), .IN_W(IN_W), .LANES(1), .LOOP_W(LOOP_W), .LOOP_MAX(100)) u_dut (
        .clk(clk), .xrst(xrst), .bus(bus), .dbg_state(dbg_state)
    );
    llr_frame_feeder #(.N(N), .W(W), .IN_W(IN_W), .LANES(4), .LOOP_W(LOOP_W), .LOOP_MAX(100)) u_dut4 (
        .clk(clk), .xrst(xrst), .bus(bus4), .dbg_state(dbg_state4)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sat_model(input int v);
        if (v > 31)       return 6'd31;
        else if (v < -31) return 6'b100001;
        else              return W'(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int v);
        int guard = 0;
        bus.s_data = IN_W'(v);
        bus.s_val  = 1'b1;
        while (!bus.s_rdy && guard < 300) begin
            tick();
            guard++;
        end
        if (!bus.s_rdy) check("s_rdy_wait", bus.s_rdy, 1);
        else exp_q.push_back(sat_model(v));
        tick();
        bus.s_val = 1'b0;
    endtask

    task automatic collect_frame();
        int guard = 0;
        while (!bus.d_val && guard < 40) begin
            tick();
            guard++;
        end
        check("feed_start", bus.d_val, 1);
        for (int b = 0; b < N; b++) begin
            logic [W-1:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check($sformatf("d_val[%0d]", b), bus.d_val, 1);
            check($sformatf("d_first[%0d]", b), bus.d_first, (b == 0));
            check($sformatf("d_data[%0d]", b), bus.d_data, e);
            tick();
        end
        check("feed_end", bus.d_val, 0);
    endtask

    task automatic decode(input logic [N-1:0] est, input int delay);
        check("wait_state", dbg_state, 2);
        check("wait_no_result", bus.r_val, 0);
        repeat (delay) tick();
        bus.dec_estimate = est;
        bus.dec_o_val    = 1'b1;
        tick();
        bus.dec_o_val    = 1'b0;
        bus.dec_estimate = '0;
        check("r_val", bus.r_val, 1);
        check("r_estimate", bus.r_estimate, est);
        check("r_timeout", bus.r_timeout, 0);
    endtask

    task automatic release_result();
        bus.r_rdy = 1'b1;
        tick();
        bus.r_rdy = 1'b0;
        check("r_val_drop", bus.r_val, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.s_data = '0;  bus.s_val = 1'b0;  bus.dec_o_val = 1'b0;
        bus.dec_estimate = '0;  bus.dec_loop = '0;  bus.r_rdy = 1'b0;
        bus4.s_data = '0; bus4.s_val = 1'b0; bus4.dec_o_val = 1'b0;
        bus4.dec_estimate = '0; bus4.dec_loop = '0; bus4.r_rdy = 1'b0;

        // Reset state
        #2;
        check("rst_s_rdy", bus.s_rdy, 0);
        check("rst_d_val", bus.d_val, 0);
        check("rst_d_data", bus.d_data, 0);
        check("rst_r_val", bus.r_val, 0);
        check("rst_r_est", bus.r_estimate, 0);
        check("rst_state", dbg_state, 0);
        repeat (3) @(posedge clk);
        #3 xrst = 1'b1;
        tick();
        check("post_rst_s_rdy", bus.s_rdy, 1);
        check("post_rst_s_rdy4", bus4.s_rdy, 1);

        // Basic frame: LLRs 1..12, convergence 30 cycles later
        for (int i = 1; i <= 12; i++) send_beat(i);
        check("lat_full_cycle", bus.d_val, 0);
        tick();
        check("lat_feed", bus.d_val, 1);
        collect_frame();
        decode(12'hA5C, 29);
        check("basic_r_sat", bus.r_sat, 0);
        release_result();

        // Saturation, then two clean frames (one per bank)
        begin
            int sv[12] = '{127, -128, 31, -31, 32, 0, 1, 2, 3, 4, 5, 6};
            for (int i = 0; i < 12; i++) send_beat(sv[i]);
        end
        collect_frame();
        decode(12'h0F1, 3);
        check("sat_r_sat", bus.r_sat, 1);
        release_result();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) send_beat(i - 6 + f);
            collect_frame();
            decode(12'h100 + N'(f), 2);
            check("clean_r_sat", bus.r_sat, 0);
            release_result();
        end

        // Timeout at dec_loop == 100
        for (int i = 0; i < 12; i++) send_beat(i);
        collect_frame();
        check("to_wait_state", dbg_state, 2);
        for (int i = 0; i <= 100; i++) begin
            bus.dec_loop     = LOOP_W'(i);
            bus.dec_estimate = 12'h3C3;
            tick();
            if (i == 99) check("to_no_early", bus.r_val, 0);
        end
        bus.dec_loop = '0;
        bus.dec_estimate = '0;
        check("to_r_val", bus.r_val, 1);
        check("to_r_timeout", bus.r_timeout, 1);
        check("to_r_est", bus.r_estimate, 12'h3C3);
        release_result();

        // Convergence and LOOP_MAX in the same cycle: convergence wins
        for (int i = 0; i < 12; i++) send_beat(11 - i);
        collect_frame();
        for (int i = 0; i <= 100; i++) begin
            bus.dec_loop     = LOOP_W'(i);
            bus.dec_o_val    = (i == 100);
            bus.dec_estimate = 12'h5A5;
            tick();
        end
        bus.dec_loop = '0; bus.dec_o_val = 1'b0; bus.dec_estimate = '0;
        check("tie_r_val", bus.r_val, 1);
        check("tie_r_timeout", bus.r_timeout, 0);
        check("tie_r_est", bus.r_estimate, 12'h5A5);
        release_result();

        // Ping-pong with result backpressure
        fork
            begin
                for (int i = 0; i < 24; i++) send_beat(i < 12 ? i : -(i - 12));
            end
            collect_frame();
        join
        check("pp_s_rdy_full", bus.s_rdy, 0);
        bus.s_data = IN_W'(20);
        bus.s_val  = 1'b1;
        decode(12'h111, 2);
        for (int k = 0; k < 5; k++) begin
            check("pp1_hold_r_val", bus.r_val, 1);
            check("pp1_hold_est", bus.r_estimate, 12'h111);
            check("pp1_blocked_s_rdy", bus.s_rdy, 0);
            check("pp1_no_feed", bus.d_val, 0);
            tick();
        end
        bus.r_rdy = 1'b1;
        tick();
        bus.r_rdy = 1'b0;
        check("pp1_r_val_drop", bus.r_val, 0);
        check("pp_freed_s_rdy", bus.s_rdy, 1);
        check("pp_no_feed_yet", bus.d_val, 0);
        fork
            begin
                for (int i = 0; i < 12; i++) send_beat(i + 20);
            end
            collect_frame();
        join
        decode(12'h222, 1);
        for (int k = 0; k < 3; k++) begin
            check("pp2_hold_est", bus.r_estimate, 12'h222);
            check("pp2_hold_to", bus.r_timeout, 0);
            tick();
        end
        release_result();
        collect_frame();
        decode(12'h333, 1);
        release_result();
        check("pp_queue_empty", exp_q.size(), 0);

        // Four-lane packing
        for (int i = 0; i < 12; i++) begin
            bus4.s_data = IN_W'(i);
            bus4.s_val  = 1'b1;
            check("l4_s_rdy", bus4.s_rdy, 1);
            tick();
        end
        bus4.s_val = 1'b0;
        tick();
        for (int b = 0; b < 3; b++) begin
            logic [4*W-1:0] e4;
            e4 = '0;
            for (int l = 0; l < 4; l++) e4[l*W +: W] = W'(b * 4 + l);
            check($sformatf("l4_d_val[%0d]", b), bus4.d_val, 1);
            check($sformatf("l4_d_first[%0d]", b), bus4.d_first, (b == 0));
            check($sformatf("l4_d_data[%0d]", b), bus4.d_data, e4);
            tick();
        end
        check("l4_feed_end", bus4.d_val, 0);
        check("l4_wait_state", dbg_state4, 2);
        bus4.dec_o_val = 1'b1;
        bus4.dec_estimate = 12'hBEE;
        tick();
        bus4.dec_o_val = 1'b0;
        check("l4_r_val", bus4.r_val, 1);
        check("l4_r_est", bus4.r_estimate, 12'hBEE);
        bus4.r_rdy = 1'b1;
        tick();
        bus4.r_rdy = 1'b0;

        // Reset pulse during FEED beat 5
        for (int i = 0; i < 12; i++) send_beat(i + 1);
        begin
            int guard = 0;
            while (!bus.d_val && guard < 40) begin
                tick();
                guard++;
            end
        end
        repeat (5) tick();
        check("mid_beat5_data", bus.d_data, 6);
        #2 xrst = 1'b0;
        #1;
        check("mid_rst_d_val", bus.d_val, 0);
        check("mid_rst_d_first", bus.d_first, 0);
        check("mid_rst_d_data", bus.d_data, 0);
        check("mid_rst_s_rdy", bus.s_rdy, 0);
        check("mid_rst_r_val", bus.r_val, 0);
        check("mid_rst_state", dbg_state, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_rst_s_rdy_hold", bus.s_rdy, 0);
        #2 xrst = 1'b1;
        tick();
        check("mid_post_s_rdy", bus.s_rdy, 1);
        for (int i = 0; i < 12; i++) send_beat(30 - i);
        collect_frame();
        decode(12'h7E1, 4);
        check("fresh_r_sat", bus.r_sat, 0);
        release_result();

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
